// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory bus arbiter.
//   arb_state_t : arbiter FSM state
//   MEMRW_*     : pipeline MemRW encodings (11 is illegal and decodes as none)
//   TMO_W       : width of the bus timeout counter
package mem_arb_pkg;
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_IFETCH = 2'd1,
      ST_DREAD  = 2'd2,
      ST_DWRITE = 2'd3
   } arb_state_t;

   localparam logic [1:0] MEMRW_LOAD  = 2'b10;
   localparam logic [1:0] MEMRW_STORE = 2'b01;
   localparam int         TMO_W       = 8;
endpackage

// File: rtl/mem_arb_wbuf.sv
// One-entry posted-write buffer.
//   accept     : latch acc_addr/acc_data/acc_be, entry becomes valid
//   drain_done : entry has been written on the bus, entry becomes empty
//   cmp_word   : word address of the current load, for the conflict compare
//   valid/addr/data/be : buffered store
//   conflict   : buffered store targets the same word as cmp_word
// accept wins over drain_done so a store can refill the buffer in the
// same cycle the previous entry retires.
module mem_arb_wbuf
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              accept,
   input  logic [ADDR_W-1:0] acc_addr,
   input  logic [DATA_W-1:0] acc_data,
   input  logic [3:0]        acc_be,
   input  logic              drain_done,
   input  logic [ADDR_W-3:0] cmp_word,
   output logic              valid,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data,
   output logic [3:0]        be,
   output logic              conflict
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
         addr  <= '0;
         data  <= '0;
         be    <= '0;
      end else if (accept) begin
         valid <= 1'b1;
         addr  <= acc_addr;
         data  <= acc_data;
         be    <= acc_be;
      end else if (drain_done) begin
         valid <= 1'b0;
      end
   end

   assign conflict = valid && (addr[ADDR_W-1:2] == cmp_word);
endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one external memory port between instruction fetch and the
// MEM-stage load/store unit, with a posted-write buffer for stores.
//   clk, rst       : clock, async active-high reset
//   pipe_adv       : pipeline advances at this edge; clears per-instruction flags
//   i_req/i_addr/i_cancel, iready_n/i_rdata : fetch side
//   d_rw/d_addr/d_wdata/d_be, dready_n/d_rdata/dbusy : load/store side
//   m_req/m_we/m_addr/m_wdata/m_be, m_ack/m_rdata : external bus
//   err            : sticky bus timeout
module mem_bus_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pipe_adv,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_cancel,
   output logic              iready_n,
   output logic [DATA_W-1:0] i_rdata,
   input  logic [1:0]        d_rw,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic [3:0]        d_be,
   output logic              dready_n,
   output logic [DATA_W-1:0] d_rdata,
   output logic              dbusy,
   output logic              m_req,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   output logic [3:0]        m_be,
   input  logic              m_ack,
   input  logic [DATA_W-1:0] m_rdata,
   output logic              err
);
   arb_state_t        state;
   logic              i_done, d_done, i_kill, st_acc;
   logic [TMO_W-1:0]  tcnt;
   logic              wb_valid, wb_conflict;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic [3:0]        wb_be;

   logic is_load, is_store, arb_en, ack_w, i_fin, d_fin;
   logic load_go, drain_go, fetch_go, st_accept;

   assign is_load  = (d_rw == MEMRW_LOAD);
   assign is_store = (d_rw == MEMRW_STORE);
   assign arb_en   = (state == ST_IDLE) || m_ack;
   assign ack_w    = (state == ST_DWRITE) && m_ack;
   assign d_fin    = (state == ST_DREAD) && m_ack;
   // A fetch cancelled while in flight still completes on the bus, but its
   // data is dropped.
   assign i_fin    = (state == ST_IFETCH) && m_ack && !i_kill && !i_cancel;

   // Requests already on the bus are excluded so the ack cycle cannot
   // re-issue the transaction that is just finishing.
   assign load_go  = is_load && !d_done && (state != ST_DREAD) && !wb_conflict;
   assign drain_go = wb_valid && (state != ST_DWRITE);
   assign fetch_go = i_req && !i_done && !i_cancel && (state != ST_IFETCH);

   assign st_accept = is_store && !st_acc && (!wb_valid || ack_w);
   assign dbusy     = is_store && !st_acc && wb_valid && !ack_w;

   mem_arb_wbuf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wbuf (
      .clk        (clk),
      .rst        (rst),
      .accept     (st_accept),
      .acc_addr   (d_addr),
      .acc_data   (d_wdata),
      .acc_be     (d_be),
      .drain_done (ack_w),
      .cmp_word   (d_addr[ADDR_W-1:2]),
      .valid      (wb_valid),
      .addr       (wb_addr),
      .data       (wb_data),
      .be         (wb_be),
      .conflict   (wb_conflict)
   );

   // Bus FSM: grants in IDLE or in the ack cycle (back-to-back issue).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         m_req   <= 1'b0;
         m_we    <= 1'b0;
         m_addr  <= '0;
         m_wdata <= '0;
         m_be    <= '0;
         tcnt    <= '0;
         err     <= 1'b0;
      end else if (arb_en) begin
         tcnt <= '0;
         if (load_go) begin
            state   <= ST_DREAD;
            m_req   <= 1'b1;
            m_we    <= 1'b0;
            m_addr  <= d_addr;
            m_wdata <= '0;
            m_be    <= d_be;
         end else if (drain_go) begin
            state   <= ST_DWRITE;
            m_req   <= 1'b1;
            m_we    <= 1'b1;
            m_addr  <= wb_addr;
            m_wdata <= wb_data;
            m_be    <= wb_be;
         end else if (fetch_go) begin
            state   <= ST_IFETCH;
            m_req   <= 1'b1;
            m_we    <= 1'b0;
            m_addr  <= i_addr;
            m_wdata <= '0;
            m_be    <= 4'hF;
         end else begin
            state <= ST_IDLE;
            m_req <= 1'b0;
            m_we  <= 1'b0;
         end
      end else if (tcnt == TMO_W'(TIMEOUT)) begin
         err <= 1'b1;            // keep waiting; counter saturates
      end else begin
         tcnt <= tcnt + 1'b1;
      end
   end

   // Per-instruction completion flags. The ready strobes favour a
   // completion over pipe_adv so in-flight results are always delivered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         iready_n <= 1'b1;
         dready_n <= 1'b1;
         i_rdata  <= '0;
         d_rdata  <= '0;
         i_done   <= 1'b0;
         d_done   <= 1'b0;
         i_kill   <= 1'b0;
         st_acc   <= 1'b0;
      end else begin
         if (d_fin) begin
            d_rdata  <= m_rdata;
            dready_n <= 1'b0;
         end else if (pipe_adv) begin
            dready_n <= 1'b1;
         end
         if (pipe_adv)   d_done <= 1'b0;
         else if (d_fin) d_done <= 1'b1;

         if (i_fin) begin
            i_rdata  <= m_rdata;
            iready_n <= 1'b0;
         end else if (pipe_adv || i_cancel) begin
            iready_n <= 1'b1;
         end
         if (pipe_adv || i_cancel) i_done <= 1'b0;
         else if (i_fin)           i_done <= 1'b1;

         if (state == ST_IFETCH && m_ack)         i_kill <= 1'b0;
         else if (state == ST_IFETCH && i_cancel) i_kill <= 1'b1;

         if (pipe_adv)       st_acc <= 1'b0;
         else if (st_accept) st_acc <= 1'b1;
      end
   end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
   import mem_arb_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pipe_adv, i_req, i_cancel, iready_n, dready_n, dbusy;
   logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
   logic [1:0]  d_rw;
   logic [3:0]  d_be, m_be;
   logic        m_req, m_we, m_ack, err;
   logic [31:0] m_addr, m_wdata, m_rdata;

   mem_bus_arbiter dut (
      .clk(clk), .rst(rst), .pipe_adv(pipe_adv),
      .i_req(i_req), .i_addr(i_addr), .i_cancel(i_cancel),
      .iready_n(iready_n), .i_rdata(i_rdata),
      .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .dready_n(dready_n), .d_rdata(d_rdata), .dbusy(dbusy),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_be(m_be), .m_ack(m_ack), .m_rdata(m_rdata), .err(err)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int nwr = 0;
   always @(posedge clk) if (m_req && m_ack && m_we) nwr <= nwr + 1;

   // Reference memory (program order) and bus memory (what the DUT wrote).
   logic [31:0] refm [logic [31:0]];
   logic [31:0] bmem [logic [31:0]];
   logic        in_txn;
   int          lat_left, stab_err;
   logic [31:0] txn_addr;

   typedef struct {
      logic [1:0]  rw;
      logic [31:0] addr, wdata;
      logic [3:0]  be;
      logic [31:0] rdata;
      logic        exp_req, exp_we;
      logic [31:0] exp_wdata;
   } vec_t;
   vec_t tv [6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc(); @(posedge clk); #2; endtask

   task automatic idle_inputs();
      pipe_adv = 0; i_req = 0; i_addr = 0; i_cancel = 0; d_rw = 0;
      d_addr = 0; d_wdata = 0; d_be = 0; m_ack = 0; m_rdata = 0;
   endtask

   task automatic pipe_step(); pipe_adv = 1; cyc(); pipe_adv = 0; endtask

   task automatic chk_rst(input string t);
      chk({t, "_iready_n"}, iready_n, 1); chk({t, "_dready_n"}, dready_n, 1);
      chk({t, "_dbusy"}, dbusy, 0);       chk({t, "_m_req"}, m_req, 0);
      chk({t, "_m_we"}, m_we, 0);         chk({t, "_m_addr"}, m_addr, 0);
      chk({t, "_m_wdata"}, m_wdata, 0);   chk({t, "_m_be"}, {28'h0, m_be}, 0);
      chk({t, "_i_rdata"}, i_rdata, 0);   chk({t, "_d_rdata"}, d_rdata, 0);
      chk({t, "_err"}, err, 0);
   endtask

   // Waits (bounded) for a request, lets it sit lat cycles, then acks it.
   task automatic bus_ack(input int lat, input logic [31:0] rd,
                          output logic [31:0] a, output logic we);
      int n = 0;
      while (!m_req && n < 20) begin cyc(); n++; end
      chk("bus_req_seen", m_req, 1);
      a = '0; we = 0;
      if (!m_req) return;
      repeat (lat) cyc();
      a = m_addr; we = m_we;
      m_ack = 1; m_rdata = rd; cyc(); m_ack = 0; m_rdata = 0;
   endtask

   function automatic logic [31:0] wkey(input logic [31:0] a);
      return {2'b00, a[31:2]};
   endfunction
   function automatic logic [31:0] init_word(input logic [31:0] a);
      return {a[31:2], 2'b00} ^ 32'h5A00_0000 ^ {a[15:0], 16'h0};
   endfunction
   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] be);
      logic [31:0] r = o;
      for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
      return r;
   endfunction
   function automatic logic [31:0] bm_rd(input logic [31:0] a);
      if (bmem.exists(wkey(a))) return bmem[wkey(a)];
      return init_word(a);
   endfunction
   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      if (refm.exists(wkey(a))) return refm[wkey(a)];
      return init_word(a);
   endfunction

   // Random-latency memory slave; also checks request stability.
   task automatic respond();
      m_ack = 0;
      if (m_req) begin
         if (!in_txn) begin
            in_txn = 1; lat_left = $urandom_range(1, 3); txn_addr = m_addr;
         end else if (m_addr !== txn_addr) stab_err++;
         lat_left--;
         if (lat_left == 0) begin
            m_ack = 1; m_rdata = bm_rd(m_addr);
            if (m_we) bmem[wkey(m_addr)] = merge(bm_rd(m_addr), m_wdata, m_be);
            in_txn = 0;
         end
      end
   endtask

   initial begin
      logic [31:0] a, old, pc, da, wd, exp_i, exp_d;
      logic        we, done;
      logic [3:0]  be;
      int          n, base, kind, nst;

      tv[0] = '{MEMRW_LOAD,  32'h0000_1000, 32'h0,         4'hF, 32'hCAFE_BABE, 1, 0, 32'h0};
      tv[1] = '{MEMRW_STORE, 32'h0000_1008, 32'h1234_5678, 4'h3, 32'h0,         1, 1, 32'h1234_5678};
      tv[2] = '{2'b11,       32'h0000_100C, 32'hFFFF_FFFF, 4'hF, 32'h0,         0, 0, 32'h0};
      tv[3] = '{2'b00,       32'h0000_1010, 32'h0,         4'hF, 32'h0,         0, 0, 32'h0};
      tv[4] = '{MEMRW_LOAD,  32'hFFFF_FFFC, 32'h0,         4'h5, 32'h0000_0001, 1, 0, 32'h0};
      tv[5] = '{MEMRW_STORE, 32'h0000_0010, 32'hA5A5_A5A5, 4'h8, 32'h0,         1, 1, 32'hA5A5_A5A5};

      idle_inputs();
      rst = 1; cyc(); cyc();
      chk_rst("reset");
      rst = 0; cyc();

      // Single data transactions from idle
      for (int v = 0; v < 6; v++) begin
         idle_inputs();
         d_rw = tv[v].rw; d_addr = tv[v].addr; d_wdata = tv[v].wdata; d_be = tv[v].be;
         #1 chk($sformatf("tv%0d_dbusy", v), dbusy, 0);
         if (tv[v].rw == MEMRW_STORE) begin pipe_step(); d_rw = 0; end
         n = 0;
         while (!m_req && n < 4) begin cyc(); n++; end
         chk($sformatf("tv%0d_req", v), m_req, tv[v].exp_req);
         if (m_req) begin
            chk($sformatf("tv%0d_we", v), m_we, tv[v].exp_we);
            chk($sformatf("tv%0d_addr", v), m_addr, tv[v].addr);
            chk($sformatf("tv%0d_wdata", v), m_wdata, tv[v].exp_wdata);
            chk($sformatf("tv%0d_be", v), {28'h0, m_be}, {28'h0, tv[v].be});
            m_ack = 1; m_rdata = tv[v].rdata; cyc(); m_ack = 0;
            if (tv[v].rw == MEMRW_LOAD) begin
               chk($sformatf("tv%0d_dready", v), dready_n, 0);
               chk($sformatf("tv%0d_rdata", v), d_rdata, tv[v].rdata);
            end
         end
         d_rw = 0; pipe_step();
         chk($sformatf("tv%0d_dready_clr", v), dready_n, 1);
      end

      // 1: fetch with ack two cycles after request
      idle_inputs(); i_req = 1; i_addr = 32'h100; cyc();
      chk("t1_req", m_req, 1); chk("t1_addr", m_addr, 32'h100); chk("t1_we", m_we, 0);
      cyc(); cyc();
      chk("t1_pre_ack", iready_n, 1);
      m_ack = 1; m_rdata = 32'h13; cyc(); m_ack = 0;
      chk("t1_iready", iready_n, 0); chk("t1_rdata", i_rdata, 32'h13);
      cyc(); cyc();
      chk("t1_hold", iready_n, 0); chk("t1_no_refetch", m_req, 0);
      i_req = 0; pipe_step();
      chk("t1_release", iready_n, 1);

      // 2: load beats fetch, fetch issued back-to-back
      idle_inputs();
      d_rw = MEMRW_LOAD; d_addr = 32'h2000; d_be = 4'hF; i_req = 1; i_addr = 32'h104;
      bus_ack(1, 32'hDEAD_0001, a, we);
      chk("t2_first_addr", a, 32'h2000); chk("t2_first_we", we, 0);
      chk("t2_dready", dready_n, 0); chk("t2_drdata", d_rdata, 32'hDEAD_0001);
      chk("t2_b2b_req", m_req, 1); chk("t2_b2b_addr", m_addr, 32'h104);
      bus_ack(1, 32'h33, a, we);
      chk("t2_fetch_addr", a, 32'h104);
      chk("t2_iready", iready_n, 0); chk("t2_irdata", i_rdata, 32'h33);
      d_rw = 0; i_req = 0; pipe_step();
      chk("t2_clr_d", dready_n, 1); chk("t2_clr_i", iready_n, 1);

      // 3: store buffering, dbusy while draining, no duplicate writes
      idle_inputs(); base = nwr;
      d_rw = MEMRW_STORE; d_addr = 32'h3000; d_wdata = 32'h1111_1111; d_be = 4'hF;
      #1 chk("t3_accept1", dbusy, 0);
      pipe_step();
      d_addr = 32'h3004; d_wdata = 32'h2222_2222;
      #1 chk("t3_busy_full", dbusy, 1);
      cyc();
      chk("t3_drain_we", m_we, 1); chk("t3_drain_addr", m_addr, 32'h3000);
      chk("t3_drain_data", m_wdata, 32'h1111_1111); chk("t3_busy_wait", dbusy, 1);
      cyc();
      chk("t3_busy_wait2", dbusy, 1);
      m_ack = 1;
      #1 chk("t3_busy_ackcyc", dbusy, 0);
      cyc(); m_ack = 0;
      chk("t3_stalled_busy", dbusy, 0);
      bus_ack(1, 32'h0, a, we);
      chk("t3_second_addr", a, 32'h3004); chk("t3_second_we", we, 1);
      repeat (3) cyc();
      chk("t3_no_dup_req", m_req, 0); chk("t3_write_count", nwr - base, 2);
      d_rw = 0; pipe_step();

      // 4: load to a buffered address forces the drain first
      idle_inputs();
      d_rw = MEMRW_STORE; d_addr = 32'h3000; d_wdata = 32'h55AA_55AA; d_be = 4'hF;
      pipe_step();
      d_rw = MEMRW_LOAD;
      bus_ack(1, 32'h0, a, we);
      chk("t4_first_we", we, 1); chk("t4_first_addr", a, 32'h3000);
      bus_ack(1, 32'h55AA_55AA, a, we);
      chk("t4_second_we", we, 0); chk("t4_second_addr", a, 32'h3000);
      chk("t4_dready", dready_n, 0); chk("t4_rdata", d_rdata, 32'h55AA_55AA);
      d_rw = 0; pipe_step();

      // 5: cancel an in-flight fetch
      idle_inputs(); old = i_rdata;
      i_req = 1; i_addr = 32'h200; cyc();
      chk("t5_req", m_req, 1); chk("t5_addr", m_addr, 32'h200);
      i_cancel = 1; cyc(); i_cancel = 0; i_addr = 32'h300;
      m_ack = 1; m_rdata = 32'h0BAD_0BAD; cyc(); m_ack = 0;
      chk("t5_iready", iready_n, 1); chk("t5_rdata_kept", i_rdata, old);
      bus_ack(1, 32'h0030_00AA, a, we);
      chk("t5_new_addr", a, 32'h300);
      chk("t5_new_iready", iready_n, 0); chk("t5_new_rdata", i_rdata, 32'h0030_00AA);
      i_req = 0; pipe_step();

      // Randomised instruction stream against the reference memory model
      idle_inputs(); rst = 1; cyc(); rst = 0; cyc();
      in_txn = 0; stab_err = 0; base = nwr; nst = 0;
      for (int k = 0; k < 150; k++) begin
         pc = $urandom_range(0, 1023) * 4; kind = $urandom_range(0, 2);
         da = 32'h2000 + $urandom_range(0, 7) * 4; wd = $urandom; be = 4'($urandom_range(0, 15));
         exp_i = init_word(pc); exp_d = ref_rd(da); done = 0;
         for (int c = 0; c < 60 && !done; c++) begin
            @(posedge clk); #1;
            pipe_adv = 0; i_req = 1; i_addr = pc; d_addr = da; d_wdata = wd;
            d_rw = (kind == 1) ? MEMRW_LOAD : (kind == 2) ? MEMRW_STORE : 2'b00;
            d_be = (kind == 1) ? 4'hF : be;
            respond();
            #1;
            if (!(iready_n || (kind == 1 && dready_n) || (kind == 2 && dbusy))) begin
               chk("rnd_fetch", i_rdata, exp_i);
               if (kind == 1) chk("rnd_load", d_rdata, exp_d);
               if (kind == 2) begin refm[wkey(da)] = merge(ref_rd(da), wd, be); nst++; end
               pipe_adv = 1; done = 1;
            end
         end
         if (!done) begin
            checks++; errors++;
            $display("FAIL rnd_progress: instruction %0d stalled past 60 cycles", k);
            break;
         end
      end
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         pipe_adv = 0; i_req = 0; d_rw = 0;
         respond();
      end
      @(posedge clk); #1; m_ack = 0;
      for (int w = 0; w < 8; w++)
         chk($sformatf("rnd_mem%0d", w), bm_rd(32'h2000 + w * 4), ref_rd(32'h2000 + w * 4));
      chk("rnd_write_count", nwr - base, nst);
      chk("rnd_bus_stable", stab_err, 0);

      // 6: bus timeout, sticky err, reset mid-wait
      idle_inputs(); i_req = 1; i_addr = 32'h400; cyc();
      chk("t6_req", m_req, 1);
      repeat (250) cyc();
      chk("t6_err_early", err, 0);
      repeat (10) cyc();
      chk("t6_err_set", err, 1); chk("t6_still_wait", m_req, 1);
      chk("t6_addr_held", m_addr, 32'h400);
      m_ack = 1; m_rdata = 32'h77; cyc(); m_ack = 0;
      chk("t6_err_sticky", err, 1); chk("t6_late_fetch", i_rdata, 32'h77);
      i_addr = 32'h404; pipe_step(); cyc();
      chk("t6_req2", m_req, 1);
      rst = 1;
      #1 chk_rst("t6_rst");
      idle_inputs(); cyc(); rst = 0; cyc();
      chk("t6_after_rst_err", err, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
